// File: rtl/alu_mc.sv
// alu_mc: multi-cycle parametrised ALU with valid/ready handshakes.
//   Single-cycle ops (AND, ADD, XOR, SLT, SNE, zero-length shifts) finish at
//   the transfer edge. Shifts run one bit per cycle. MUL is a shift-add over
//   all WIDTH bits of b.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        operand handshake (in_ready only in IDLE)
//   alu_input_a, alu_input_b   operands (b is the shift amount for shifts)
//   alu_opcode                 3-bit operation code
//   out_valid / out_ready      result handshake
//   alu_out, carry, zero       registered result, carry/shift-out, zero flag
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | waiting for operands, in_ready=1
// BUSY   | iterating a shift or multiply
// DONE   | result presented, out_valid=1
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_input_a,
  input  logic [WIDTH-1:0] alu_input_b,
  input  logic [2:0]       alu_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry,
  output logic             zero
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SNE = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // WIDTH always fits in WIDTH bits (WIDTH < 2**WIDTH), so the clamp compare
  // can be done at operand width.
  localparam logic [WIDTH-1:0] W_LIM    = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] work;    // shift register / shifted multiplicand
  logic [WIDTH-1:0] mplier;  // multiplier, consumed LSB first
  logic [WIDTH-1:0] acc;

  logic             accept;
  logic             is_shift;
  logic             multi;
  logic             last;
  logic [CNT_W-1:0] n_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] work_sll;
  logic [WIDTH-1:0] work_srl;
  logic [WIDTH-1:0] acc_next;

  assign accept   = (state == S_IDLE) && in_valid;
  assign is_shift = (alu_opcode == OP_SLL) || (alu_opcode == OP_SRL);
  // b below WIDTH always fits in CNT_W bits; larger amounts clamp to WIDTH.
  assign n_in     = (alu_input_b >= W_LIM) ? CNT_FULL : alu_input_b[CNT_W-1:0];
  assign multi    = (is_shift && (n_in != '0)) || (alu_opcode == OP_MUL);
  assign last     = (cnt == CNT_ONE);
  assign sum      = {1'b0, alu_input_a} + {1'b0, alu_input_b};
  assign work_sll = {work[WIDTH-2:0], 1'b0};
  assign work_srl = {1'b0, work[WIDTH-1:1]};
  assign acc_next = mplier[0] ? (acc + work) : acc;
  assign zero     = (alu_out == '0);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid)  state_nxt = multi ? S_BUSY : S_DONE;
      S_BUSY: if (last)      state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // outputs depend only on state
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_q    <= '0;
      work    <= '0;
      mplier  <= '0;
      acc     <= '0;
      alu_out <= '0;
      carry   <= 1'b0;
    end else if (accept) begin
      op_q <= alu_opcode;
      case (alu_opcode)
        OP_AND: begin
          alu_out <= alu_input_a & alu_input_b;
          carry   <= 1'b0;
        end
        OP_ADD: begin
          alu_out <= sum[WIDTH-1:0];
          carry   <= sum[WIDTH];
        end
        OP_XOR: begin
          alu_out <= alu_input_a ^ alu_input_b;
          carry   <= 1'b0;
        end
        OP_SLT: begin
          alu_out <= {{(WIDTH-1){1'b0}}, (alu_input_a < alu_input_b)};
          carry   <= 1'b0;
        end
        OP_SNE: begin
          alu_out <= {{(WIDTH-1){1'b0}}, (alu_input_a != alu_input_b)};
          carry   <= 1'b0;
        end
        OP_SLL, OP_SRL: begin
          if (n_in == '0) begin
            alu_out <= alu_input_a;
            carry   <= 1'b0;
          end else begin
            work <= alu_input_a;
            cnt  <= n_in;
          end
        end
        OP_MUL: begin
          work   <= alu_input_a;
          mplier <= alu_input_b;
          acc    <= '0;
          cnt    <= CNT_FULL;
        end
        default: ;
      endcase
    end else if (state == S_BUSY) begin
      cnt <= cnt - CNT_ONE;
      case (op_q)
        OP_SLL: begin
          work <= work_sll;
          if (last) begin
            alu_out <= work_sll;
            carry   <= work[WIDTH-1];
          end
        end
        OP_SRL: begin
          work <= work_srl;
          if (last) begin
            alu_out <= work_srl;
            carry   <= work[0];
          end
        end
        OP_MUL: begin
          acc    <= acc_next;
          work   <= work_sll;
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          if (last) begin
            alu_out <= acc_next;
            carry   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_input_a;
  logic [7:0] alu_input_b;
  logic [2:0] alu_opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_out;
  logic       carry;
  logic       zero;

  int n_chk  = 0;
  int n_pass = 0;

  alu_mc #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_input_a (alu_input_a),
    .alu_input_b (alu_input_b),
    .alu_opcode  (alu_opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_out     (alu_out),
    .carry       (carry),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE (called #1 after an edge), wait for the result,
  // check latency and result, then hand it off with out_ready=1.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int lat, input logic [7:0] exp_out,
                        input logic exp_c);
    int cyc;
    out_ready   = 1'b1;
    chk({tag, ".in_ready"}, in_ready, 1);
    alu_opcode  = op;
    alu_input_a = a;
    alu_input_b = b;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
    alu_input_a = 8'hFF;
    alu_input_b = 8'hFF;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, ".latency"}, cyc, lat);
    chk({tag, ".out"}, alu_out, exp_out);
    chk({tag, ".carry"}, carry, exp_c);
    chk({tag, ".zero"}, zero, exp_out == 8'h00);
    tick();
    chk({tag, ".handoff"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_opcode  = 3'b000;
    alu_input_a = 8'h00;
    alu_input_b = 8'h00;
    #12;
    chk("reset.out_valid", out_valid, 0);
    chk("reset.in_ready", in_ready, 1);
    chk("reset.alu_out", alu_out, 0);
    chk("reset.carry", carry, 0);
    chk("reset.zero", zero, 1);
    rst_n = 1'b1;
    tick();

    run_op("add",   3'b001, 8'd200, 8'd100, 1, 8'h2C, 1'b1);
    run_op("sll3",  3'b100, 8'h81,  8'd3,   4, 8'h08, 1'b0);
    run_op("sll0",  3'b100, 8'h81,  8'd0,   1, 8'h81, 1'b0);
    run_op("sll1",  3'b100, 8'h81,  8'd1,   2, 8'h02, 1'b1);
    run_op("srl9",  3'b101, 8'hF0,  8'd9,   9, 8'h00, 1'b1);
    run_op("srl4",  3'b101, 8'hF8,  8'd4,   5, 8'h0F, 1'b1);
    run_op("mul",   3'b111, 8'd13,  8'd11,  9, 8'h8F, 1'b0);
    run_op("mul16", 3'b111, 8'd16,  8'd16,  9, 8'h00, 1'b0);
    run_op("mulff", 3'b111, 8'hFF,  8'hFF,  9, 8'h01, 1'b0);
    run_op("and",   3'b000, 8'hCC,  8'hAA,  1, 8'h88, 1'b0);
    run_op("xor",   3'b010, 8'h3C,  8'h0F,  1, 8'h33, 1'b0);
    run_op("slt1",  3'b011, 8'd3,   8'd7,   1, 8'h01, 1'b0);
    run_op("slt0",  3'b011, 8'd7,   8'd7,   1, 8'h00, 1'b0);
    run_op("sne1",  3'b110, 8'd5,   8'd6,   1, 8'h01, 1'b0);

    // backpressure: SNE 5,5 held while inputs churn
    run_op("nz",    3'b010, 8'hF0,  8'h0F,  1, 8'hFF, 1'b0);
    out_ready   = 1'b0;
    alu_opcode  = 3'b110;
    alu_input_a = 8'd5;
    alu_input_b = 8'd5;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp.valid", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      in_valid    = ~in_valid;
      alu_opcode  = 3'b001;
      alu_input_a = 8'(8'h11 * (i + 1));
      alu_input_b = 8'hE0;
      tick();
      chk("bp.hold", {out_valid, in_ready, alu_out, carry, zero}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp.release", {out_valid, in_ready}, 2'b01);
    chk("bp.kept", alu_out, 8'h00);

    // mid-operation reset
    run_op("pre", 3'b010, 8'h3C, 8'hFF, 1, 8'hC3, 1'b0);
    alu_opcode  = 3'b111;
    alu_input_a = 8'd13;
    alu_input_b = 8'd11;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mr.busy", in_ready, 0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr.reset", {out_valid, in_ready, alu_out, carry, zero}, {1'b1 ^ 1'b1, 1'b1, 8'h00, 1'b0, 1'b1});
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mr.silent", out_valid, 0);
    end
    run_op("mr.xor", 3'b010, 8'hAA, 8'h0F, 1, 8'hA5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
